// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divide, one bit per cycle.
// Holds the pipeline while busy and strobes remainder/quotient into HI/LO.
module div_seq_ctrl #(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  DZ_LO  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              cancel_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [1:0]        writeHILO_o,
  output logic [DATA_W-1:0] HI_data_o,
  output logic [DATA_W-1:0] LO_data_o,
  output logic              div_zero_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rem_q, quo_q, dsr_q;
  logic              neg_q, neg_r, dz_q;

  logic              accept, last, div_zero;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              fits;
  logic [DATA_W-1:0] rem_nx;

  assign accept   = (state == IDLE) & start_i & ~cancel_i;
  assign last     = (count == CW'(DATA_W - 1));
  assign div_zero = (divisor_i == '0);

  assign a_neg = signed_i & dividend_i[DATA_W-1];
  assign b_neg = signed_i & divisor_i[DATA_W-1];
  assign abs_a = a_neg ? -dividend_i : dividend_i;
  assign abs_b = b_neg ? -divisor_i  : divisor_i;

  // quo_q doubles as the dividend shift register; its MSB feeds the remainder
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_sub = rem_sh - {1'b0, dsr_q};
  assign fits    = (rem_sh >= {1'b0, dsr_q});
  assign rem_nx  = fits ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = div_zero ? DONE : BUSY;
      BUSY: begin
        if (cancel_i)  state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      count <= '0;
      if (div_zero) begin
        rem_q <= dividend_i;
        quo_q <= DZ_LO;
        dsr_q <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        dz_q  <= 1'b1;
      end else begin
        rem_q <= '0;
        quo_q <= abs_a;
        dsr_q <= abs_b;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz_q  <= 1'b0;
      end
    end else if (state == BUSY) begin
      rem_q <= rem_nx;
      quo_q <= {quo_q[DATA_W-2:0], fits};
      count <= count + CW'(1);
    end
  end

  always_comb begin
    result_valid_o = (state == DONE) & ~cancel_i;
    stall_o        = accept | ((state == BUSY) & ~cancel_i);
    busy_o         = (state != IDLE);
    writeHILO_o    = {2{result_valid_o}};
    div_zero_o     = result_valid_o & dz_q;
    HI_data_o      = '0;
    LO_data_o      = '0;
    if (result_valid_o) begin
      HI_data_o = neg_r ? -rem_q : rem_q;
      LO_data_o = neg_q ? -quo_q : quo_q;
    end
  end

endmodule
